// File: rtl/time_counter.sv
// Timekeeping core: 1 s prescaler, binary hh:mm:ss counters, set-mode FSM.
// Optional HOUR12_EN maps the 0-23 internal hour to a 12-hour display plus pm.
module time_counter #(
  parameter int CLK_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic [1:0] mode,
  output logic       sec_pulse
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    BAD      = 2'b11
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0] presc;
  logic [5:0]    hr_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;
  logic          pulse_q;

  logic tick;
  logic inc_ok;
  logic sec_wrap;
  logic min_wrap;

  assign tick     = (state == RUN) && (presc == PMAX);
  assign inc_ok   = inc_btn && !mode_btn;
  assign sec_wrap = (sec_q == 6'd59);
  assign min_wrap = (min_q == 6'd59);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:      if (mode_btn) state_nx = SET_HOUR;
      SET_HOUR: if (mode_btn) state_nx = SET_MIN;
      SET_MIN:  if (mode_btn) state_nx = RUN;
      default:  state_nx = RUN;
    endcase
  end

  always_comb begin
    mode = state;
  end

  // Prescaler and seconds only move in RUN; leaving SET_MIN restarts the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      sec_q <= '0;
    end else if (state == RUN) begin
      if (tick) begin
        presc <= '0;
        sec_q <= sec_wrap ? 6'd0 : sec_q + 6'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end else if (state == SET_MIN && mode_btn) begin
      presc <= '0;
      sec_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
    end else if (tick && sec_wrap) begin
      min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
    end else if (state == SET_MIN && inc_ok) begin
      min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= '0;
    end else if (tick && sec_wrap && min_wrap) begin
      hr_q <= (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
    end else if (state == SET_HOUR && inc_ok) begin
      hr_q <= (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= 1'b0;
    else        pulse_q <= tick;
  end

  assign min       = min_q;
  assign sec       = sec_q;
  assign sec_pulse = pulse_q;

`ifdef HOUR12_EN
  always_comb begin
    hour = hr_q;
    pm   = (hr_q >= 6'd12);
    unique case (1'b1)
      (hr_q == 6'd0): hour = 6'd12;
      (hr_q > 6'd12): hour = hr_q - 6'd12;
      default:        hour = hr_q;
    endcase
  end
`else
  assign hour = hr_q;
  assign pm   = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with CLK_PER_SEC=4.
// Expectations follow the build: HOUR12_EN changes hour/pm checks.
module tb_time_counter;

  logic       clk;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       pm;
  logic [1:0] mode;
  logic       sec_pulse;

  int n_chk;
  int n_fail;

  time_counter #(.CLK_PER_SEC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .pm        (pm),
    .mode      (mode),
    .sec_pulse (sec_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected display hour/pm for an internal 0-23 hour.
  function automatic int disp_hr(input int h);
`ifdef HOUR12_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  function automatic int disp_pm(input int h);
`ifdef HOUR12_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic press(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input int h, input int m,
                            input int s);
    check({tag, ".hour"}, int'(hour), disp_hr(h));
    check({tag, ".pm"}, int'(pm), disp_pm(h));
    check({tag, ".min"}, int'(min), m);
    check({tag, ".sec"}, int'(sec), s);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    // Reset state
    cycles(3);
    check_time("rst", 0, 0, 0);
    check("rst.mode", int'(mode), 0);
    check("rst.pulse", int'(sec_pulse), 0);

    // Count a little, then hit reset asynchronously mid-second
    rst_n = 1'b1;
    cycles(6);
    check("pre.sec", int'(sec), 1);
    #2 rst_n = 1'b0;
    #1;
    check_time("async", 0, 0, 0);
    check("async.pulse", int'(sec_pulse), 0);
    @(negedge clk);
    check("rstlow.sec", int'(sec), 0);
    rst_n = 1'b1;

    // 240 cycles: a pulse every 4th edge, sec 0..59 then min 1
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk);
      check($sformatf("cnt%0d.pulse", k), int'(sec_pulse),
            (k % 4 == 0) ? 1 : 0);
      check($sformatf("cnt%0d.sec", k), int'(sec), (k / 4) % 60);
      if (k == 236) check("cnt.sec59", int'(sec), 59);
    end
    check("cnt.min", int'(min), 1);
    check("cnt.hour", int'(hour), disp_hr(0));

    // Fresh reset, then set hours
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    press(1'b1, 1'b0);
    check("sh.mode", int'(mode), 1);
    for (int i = 0; i < 25; i++) press(1'b0, 1'b1);
    check("sh.mode2", int'(mode), 1);
    check("sh.hour", int'(hour), disp_hr(1));
    cycles(9);
    check("sh.sec", int'(sec), 0);
    check("sh.pulse", int'(sec_pulse), 0);

    // Both buttons: mode wins, hour untouched
    press(1'b1, 1'b1);
    check("both.mode", int'(mode), 2);
    check("both.hour", int'(hour), disp_hr(1));
    check("both.min", int'(min), 0);

    // Set minutes with wrap, then exit to RUN
    for (int i = 0; i < 61; i++) press(1'b0, 1'b1);
    check("sm.min", int'(min), 1);
    check("sm.hour", int'(hour), disp_hr(1));
    check("sm.sec", int'(sec), 0);
    press(1'b1, 1'b0);
    check("exit.mode", int'(mode), 0);
    check("exit.sec", int'(sec), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("exit%0d.pulse", k), int'(sec_pulse),
            (k == 4) ? 1 : 0);
      check($sformatf("exit%0d.sec", k), int'(sec), (k == 4) ? 1 : 0);
    end

    // inc_btn in RUN is ignored
    press(1'b0, 1'b1);
    check("runinc.hour", int'(hour), disp_hr(1));
    check("runinc.min", int'(min), 1);

    // Build 23:59:00, count to 23:59:59, then roll the day over
    press(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) press(1'b0, 1'b1);
    check("roll.sethr", int'(hour), disp_hr(23));
    press(1'b1, 1'b0);
    for (int i = 0; i < 58; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check_time("roll.start", 23, 59, 0);
    check("roll.mode", int'(mode), 0);
    cycles(236);
    check_time("roll.59", 23, 59, 59);
    cycles(3);
    check("roll.prepulse", int'(sec_pulse), 0);
    @(negedge clk);
    check_time("roll.wrap", 0, 0, 0);
    check("roll.pulse", int'(sec_pulse), 1);

    // Display mapping for internal hours 0, 12, 13, 23
    check("map0.hour", int'(hour), disp_hr(0));
    check("map0.pm", int'(pm), disp_pm(0));
    press(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) press(1'b0, 1'b1);
    check("map12.hour", int'(hour), disp_hr(12));
    check("map12.pm", int'(pm), disp_pm(12));
    press(1'b0, 1'b1);
    check("map13.hour", int'(hour), disp_hr(13));
    check("map13.pm", int'(pm), disp_pm(13));
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1);
    check("map23.hour", int'(hour), disp_hr(23));
    check("map23.pm", int'(pm), disp_pm(23));
    press(1'b0, 1'b1);
    check("map24.hour", int'(hour), disp_hr(0));
    check("map24.pm", int'(pm), disp_pm(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
